win_acc_requant: RTL
====================

# win_acc_requant

Accumulator and requantizer directly downstream of the signed 16-bit Winograd multiplier. It consumes a stream of products and sums each group of beats. Per group, it emits one rounded, saturated result.
- 16-bit mode: each beat is one 32-bit product; the result is 16 bits.
- 8-bit mode: each beat is two packed 16-bit products, summed in independent lanes; the result is two 8-bit values.

It sits between the element-wise multiply stage and the inverse-transform / output buffer of the Winograd LeNet datapath.

## Interface
Parameters:
- ACC_W, 48: accumulator width. Must be even. Mode 11 uses two lanes of ACC_W/2 bits each.
- SHIFT16, 8: arithmetic right shift applied in mode 00. Legal range 1..31.
- SHIFT8, 4: arithmetic right shift applied per lane in mode 11. Legal range 1..15.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  32  mode 00: one two's-complement product. Mode 11: {hi16, lo16}, two two's-complement products.
- in_bitwidth  in  2  2'b11 selects 8-bit mode. Every other value selects 16-bit mode (same decode as the multiplier).
- in_last  in  1  marks the final beat of a group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  mode 00: signed 16-bit result. Mode 11: {hi8, lo8}, two signed 8-bit results.
- out_bitwidth  out  2  latched mode of the group that produced the result.
- out_sat  out  1  at least one value in this result was clipped by saturation.

## Operation
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- in_ready = !(out_valid && !out_ready). This is independent of in_valid and in_last.
- FSM has two states.
  - IDLE: no group open.
  - ACC: group open; acc holds the partial sum.
- Beat accepted in IDLE:
  - Mode is latched from in_bitwidth.
  - acc is loaded with the sign-extended input.
  - Without in_last: go to ACC. With in_last: finish immediately and stay in IDLE.
- Beat accepted in ACC:
  - acc += sign-extended input, using the latched mode. in_bitwidth is ignored mid-group.
  - With in_last: finish and go to IDLE.
- Finish, mode 00:
  - s = acc_next (the full ACC_W-bit sum including the last beat).
  - r = (s + 2^(SHIFT16-1)) >>> SHIFT16, computed at ACC_W+1 bits.
  - Saturate r to [-32768, 32767].
- Finish, mode 11:
  - Lane hi uses in_data[31:16]; lane lo uses in_data[15:0]. Each is sign-extended to ACC_W/2 bits.
  - Lane sums wrap independently. No carry or borrow crosses the lane boundary.
  - Each lane: r = (lane + 2^(SHIFT8-1)) >>> SHIFT8, then saturate to [-128, 127].
  - out_data = {hi8, lo8}.
- Result registers: out_data, out_bitwidth and out_sat are registered and out_valid is set on finish.
  - They hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready, unless a new finish occurs in the same cycle; then the new result replaces the old one and out_valid stays 1.
- Overflow: the accumulator wraps modulo 2^ACC_W (lane: 2^(ACC_W/2)). Only the output stage saturates.

## Timing
- Reset values (rst_n low at a clock edge), all synchronous:
  - state IDLE, acc 0, out_valid 0, out_data 16'h0000, out_bitwidth 2'b00, out_sat 0.
  - in_ready is 1 after reset.
- Reset mid-group discards the partial sum and any pending result. No output is emitted for the discarded group.
- Latency: a last beat accepted at edge N gives out_valid = 1 after edge N; data is valid in that cycle.
- Throughput: one beat per cycle with no bubbles, including back-to-back single-beat groups, while out_ready = 1.
- Back-pressure: while out_valid && !out_ready, in_ready = 0. The accumulator and FSM hold.
- Raising out_ready re-enables in_ready in the same cycle (combinational path).
- Group length is unbounded. There is no beat counter.

## Test plan
- Mode 00 basic sum: beats 32'h00000100, 32'h00000200 (last) -> out_data 16'h0003, out_sat 0, out_bitwidth 2'b00. out_valid rises one cycle after the last beat.
- Mode 00 rounding and sign:
  - Single last beat 32'h00000180 -> 16'h0002.
  - Beats 32'hFFFFFF00, 32'hFFFFFF00 (last) -> 16'hFFFE.
  - Single last beat 32'hFFFFFF80 -> 16'h0000 (round half up).
- Mode 00 saturation: beats 32'h7FFFFFFF ×2 (last) -> 16'h7FFF, out_sat 1. Beats 32'h80000000 ×2 (last) -> 16'h8000, out_sat 1.
- Mode 11 lanes: three beats {16'h0010, 16'hFFF0}, last on the third -> 16'h03FD.
  - Lane isolation: 16 beats of {16'h0000, 16'hFFFF} -> 16'h00FF. Here hi = 0 is unaffected by lo's borrows, and lo = (-16+8)>>>4 = -1.
  - Lane saturation: 20 beats of {16'h7FFF, 16'h0000} -> hi 8'h7F, out_sat 1.
- Handshake and mode latch:
  - Hold out_ready = 0 for 5 cycles after a result: in_ready = 0 and out_data is stable throughout.
  - Release out_ready: the next group is accepted in the same cycle.
  - Change in_bitwidth mid-group: no effect on the group's result or out_bitwidth.
- Reset mid-group: 3 beats accepted, then rst_n low for 1 cycle -> out_valid 0, out_data 0.
  - A subsequent single beat 32'h00000100 (last) -> 16'h0001, with no residue from the discarded group.

Source files
------------

// File: rtl/win_acc_requant.sv
// win_acc_requant: group accumulator and rounding/saturating requantizer that
// sits behind the signed 16-bit Winograd multiplier. One result per group of
// beats, either one 16-bit value or two independent 8-bit lanes.
module win_acc_requant #(
  parameter int ACC_W   = 48,
  parameter int SHIFT16 = 8,
  parameter int SHIFT8  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_bitwidth,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_bitwidth,
  output logic        out_sat
);

  localparam int LW = ACC_W / 2;

  localparam logic signed [ACC_W:0] HALF16 = (ACC_W + 1)'(1) << (SHIFT16 - 1);
  localparam logic signed [ACC_W:0] MAX16  = (ACC_W + 1)'(32767);
  localparam logic signed [ACC_W:0] MIN16  = (ACC_W + 1)'(-32768);
  localparam logic signed [LW:0]    HALF8  = (LW + 1)'(1) << (SHIFT8 - 1);
  localparam logic signed [LW:0]    MAX8   = (LW + 1)'(127);
  localparam logic signed [LW:0]    MIN8   = (LW + 1)'(-128);

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_base, w_sum16, w_acc_nxt;
  logic [LW-1:0]           w_lane_hi, w_lane_lo;
  logic [1:0]              r_bw, w_bw;
  logic                    w_mode8, w_fire, w_finish;
  logic [16:0]             w_res16;
  logic [8:0]              w_res_hi, w_res_lo;
  logic                    r_out_valid, r_out_sat;
  logic [15:0]             r_out_data;
  logic [1:0]              r_out_bw;

  // Round half up at the shift point, then clip to signed 16 bits; bit 16 flags a clip.
  function automatic logic [16:0] rnd_sat16(input logic [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    t = $signed({s[ACC_W-1], s}) + HALF16;
    t = t >>> SHIFT16;
    if (t > MAX16)      return {1'b1, 16'h7FFF};
    else if (t < MIN16) return {1'b1, 16'h8000};
    else                return {1'b0, t[15:0]};
  endfunction

  // Same rounding for one lane, clipped to signed 8 bits; bit 8 flags a clip.
  function automatic logic [8:0] rnd_sat8(input logic [LW-1:0] s);
    logic signed [LW:0] t;
    t = $signed({s[LW-1], s}) + HALF8;
    t = t >>> SHIFT8;
    if (t > MAX8)      return {1'b1, 8'h7F};
    else if (t < MIN8) return {1'b1, 8'h80};
    else               return {1'b0, t[7:0]};
  endfunction

  // Downstream stall blocks new beats; releasing out_ready reopens the input at once.
  assign in_ready = !(r_out_valid && !out_ready);
  assign w_fire   = in_valid && in_ready;
  // The mode comes from the first beat and is frozen for the rest of the group.
  assign w_bw     = (r_state == S_IDLE) ? in_bitwidth : r_bw;
  assign w_mode8  = (w_bw == 2'b11);

  // Next accumulator value: a full-width sum, or two lanes that wrap independently.
  always_comb begin
    w_base    = (r_state == S_ACC) ? r_acc : '0;
    w_sum16   = w_base + {{(ACC_W-32){in_data[31]}}, in_data};
    w_lane_hi = w_base[ACC_W-1:LW] + {{(LW-16){in_data[31]}}, in_data[31:16]};
    w_lane_lo = w_base[LW-1:0]     + {{(LW-16){in_data[15]}}, in_data[15:0]};
    w_acc_nxt = w_mode8 ? {w_lane_hi, w_lane_lo} : w_sum16;
    w_res16   = rnd_sat16(w_acc_nxt);
    w_res_hi  = rnd_sat8(w_acc_nxt[ACC_W-1:LW]);
    w_res_lo  = rnd_sat8(w_acc_nxt[LW-1:0]);
  end

  // Group FSM: a non-last beat opens a group, a last beat closes it.
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    if (w_fire) begin
      if (in_last) begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_ACC;
      end
    end
  end

  // State, accumulator and latched mode; all hold while the input is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_bw    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_acc <= w_acc_nxt;
        r_bw  <= w_bw;
      end
    end
  end

  // Result register: loaded on finish, held under back-pressure, cleared when taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_bw    <= 2'b00;
      r_out_sat   <= 1'b0;
    end else if (w_finish) begin
      r_out_valid <= 1'b1;
      r_out_bw    <= w_bw;
      if (w_mode8) begin
        r_out_data <= {w_res_hi[7:0], w_res_lo[7:0]};
        r_out_sat  <= w_res_hi[8] | w_res_lo[8];
      end else begin
        r_out_data <= w_res16[15:0];
        r_out_sat  <= w_res16[16];
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_bitwidth = r_out_bw;
  assign out_sat      = r_out_sat;

endmodule
